// File: rtl/c5_reg_bank_pkg.sv
// Shared index codes and clear-FSM encoding for the c5 multi-port register bank.
package c5_reg_bank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Index codes are AW+1 bits wide; callers truncate with an explicit cast.
  function automatic logic [31:0] idx_zero(input int unsigned aw);
    return 32'(aw) & 32'd0;
  endfunction

  function automatic logic [31:0] idx_status(input int unsigned aw);
    return (32'd1 << aw) | 32'd12;
  endfunction

  function automatic logic [31:0] idx_epc(input int unsigned aw);
    return (32'd1 << aw) | 32'd14;
  endfunction

  function automatic logic [31:0] idx_vec(input int unsigned aw);
    return (32'd1 << (aw + 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/c5_reg_bank_ram.sv
// One register-file copy: synchronous write, asynchronous read.
module c5_reg_bank_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/c5_reg_bank_mp.sv
// Multi-read-port register bank with CP0 interrupt enable/EPC and a post-reset clear engine.
// Optional same-cycle write-to-read forwarding: define C5_REG_BANK_MP_BYPASS_EN.
module c5_reg_bank_mp
  import c5_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_RD = 2,
  parameter logic [31:0] IVEC   = 32'h0000_003C
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic                     I_pause,
  input  logic [NUM_RD*(AW+1)-1:0] I_rs_index,
  input  logic [AW:0]              I_rd_index,
  input  logic [WIDTH-1:0]         I_reg_dest_new,
  output logic [NUM_RD*WIDTH-1:0]  O_reg_out,
  output logic                     O_intr_enable,
  output logic                     O_busy
);

  localparam int unsigned IW    = AW + 1;
  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [IW-1:0] I_ZERO   = IW'(idx_zero(AW));
  localparam logic [IW-1:0] I_STATUS = IW'(idx_status(AW));
  localparam logic [IW-1:0] I_EPC    = IW'(idx_epc(AW));
  localparam logic [IW-1:0] I_VEC    = IW'(idx_vec(AW));

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ie_q, ie_d;

  logic             clr_c;
  logic             wr_en_c;
  logic [AW-1:0]    wr_slot_c;
  logic             ram_we_c;
  logic [AW-1:0]    ram_waddr_c;
  logic [WIDTH-1:0] ram_wdata_c;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ie_q    <= ie_d;
    end
  end

  // Clear engine: one slot per cycle, leaves CLEAR after writing the last slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_c   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_c = 1'b1;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_d = ST_CLEAR;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Interrupt enable tracks STATUS writes and exception entry, independent of stall.
  always_comb begin
    ie_d = ie_q;
    if (I_rd_index == I_EPC)         ie_d = 1'b0;
    else if (I_rd_index == I_STATUS) ie_d = I_reg_dest_new[0];
  end

  assign wr_en_c   = (I_rd_index != I_ZERO) && (I_rd_index != I_STATUS) &&
                     !I_pause && !busy_q && I_rst_n;
  assign wr_slot_c = (I_rd_index == I_EPC) ? '0 : I_rd_index[AW-1:0];

  assign ram_we_c    = I_rst_n && (clr_c || wr_en_c);
  assign ram_waddr_c = clr_c ? cnt_q : wr_slot_c;
  assign ram_wdata_c = clr_c ? '0 : I_reg_dest_new;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [IW-1:0]    idx;
    logic [AW-1:0]    slot;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] out_c;

    assign idx  = I_rs_index[k*IW +: IW];
    assign slot = (idx == I_EPC) ? '0 : idx[AW-1:0];

    c5_reg_bank_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
      .clk_i   (I_clk),
      .we_i    (ram_we_c),
      .waddr_i (ram_waddr_c),
      .wdata_i (ram_wdata_c),
      .raddr_i (slot),
      .rdata_o (rdata)
    );

    // Later assignments win: ZERO over busy over port-0 decodes over array data.
    always_comb begin
      out_c = rdata;
`ifdef C5_REG_BANK_MP_BYPASS_EN
      if (wr_en_c && (slot == wr_slot_c)) out_c = I_reg_dest_new;
`endif
      if ((k == 0) && (idx == I_STATUS)) out_c = WIDTH'(ie_q);
      if ((k == 0) && (idx == I_VEC))    out_c = WIDTH'(IVEC);
      if (busy_q)                        out_c = '0;
      if (idx == I_ZERO)                 out_c = '0;
    end

    assign O_reg_out[k*WIDTH +: WIDTH] = out_c;
  end

  assign O_intr_enable = ie_q;
  assign O_busy        = busy_q;

endmodule

// File: tb/tb_c5_reg_bank_mp.sv
// Directed scoreboard bench for c5_reg_bank_mp (default 32x32, two read ports).
module tb_c5_reg_bank_mp;

  localparam logic [5:0] ZERO   = 6'h00;
  localparam logic [5:0] STATUS = 6'h2C;
  localparam logic [5:0] EPC    = 6'h2E;
  localparam logic [5:0] VEC    = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pause;
  logic [11:0] rs_index;
  logic [5:0]  rd_index;
  logic [31:0] wdata;
  logic [63:0] reg_out;
  logic        intr_enable;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  c5_reg_bank_mp dut (
    .I_clk          (clk),
    .I_rst_n        (rst_n),
    .I_pause        (pause),
    .I_rs_index     (rs_index),
    .I_rd_index     (rd_index),
    .I_reg_dest_new (wdata),
    .O_reg_out      (reg_out),
    .O_intr_enable  (intr_enable),
    .O_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_port(input int p);
    return reg_out[p*32 +: 32];
  endfunction

  task automatic set_rs(input logic [5:0] p0, input logic [5:0] p1);
    rs_index = {p1, p0};
    #1;
  endtask

  task automatic push(input string tag, input int p, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.port = p;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, rd_port(e.port), e.val);
    end
  endtask

  task automatic write(input logic [5:0] rd, input logic [31:0] d);
    rd_index = rd;
    wdata    = d;
    step();
    rd_index = ZERO;
    wdata    = '0;
    #1;
  endtask

  // Counts cycles until busy falls, checking reads stay 0; rd/wdata are held throughout.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      push({tag, "_p0_busy_read"}, 0, 32'h0);
      push({tag, "_p1_busy_read"}, 1, 32'h0);
      drain();
      step();
      n++;
    end
    rd_index = ZERO;
    wdata    = '0;
    #1;
    check({tag, "_busy_cycles"}, 32'(n), 32'd32);
  endtask

  initial begin
    rst_n    = 1'b0;
    pause    = 1'b0;
    rs_index = '0;
    rd_index = ZERO;
    wdata    = '0;

    // Reset and initial clear sweep
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ie", 32'(intr_enable), 32'd0);
    set_rs(VEC, 6'd5);
    rst_n = 1'b1;
    #1;
    count_busy("clear1");
    check("clear1_ie", 32'(intr_enable), 32'd0);

    // Basic write and read on both ports; ZERO is never written
    write(6'd5, 32'hDEADBEEF);
    set_rs(6'd5, 6'd5);
    push("wr5_p0", 0, 32'hDEADBEEF);
    push("wr5_p1", 1, 32'hDEADBEEF);
    drain();
    write(ZERO, 32'hFFFF_FFFF);
    set_rs(ZERO, EPC);
    push("zero_p0", 0, 32'h0);
    push("zero_no_slot0_write", 1, 32'h0);
    drain();

    // CP0 STATUS / EPC / VEC
    write(STATUS, 32'h1);
    check("status_ie_set", 32'(intr_enable), 32'd1);
    set_rs(STATUS, STATUS);
    push("status_p0", 0, 32'h1);
    push("status_p1_array", 1, 32'h0);
    drain();
    write(EPC, 32'h400);
    check("epc_ie_clr", 32'(intr_enable), 32'd0);
    set_rs(EPC, ZERO);
    push("epc_p0", 0, 32'h400);
    push("zero_p1", 1, 32'h0);
    drain();
    set_rs(ZERO, EPC);
    push("zero_p0_after_epc", 0, 32'h0);
    push("epc_p1", 1, 32'h400);
    drain();
    set_rs(VEC, VEC);
    push("vec_p0", 0, 32'h3C);
    push("vec_p1_array", 1, 32'h0);
    drain();

    // Pause blocks writes but not the interrupt-enable update
    pause = 1'b1;
    write(6'd7, 32'h1234);
    write(STATUS, 32'h1);
    pause = 1'b0;
    check("pause_ie_set", 32'(intr_enable), 32'd1);
    set_rs(6'd7, 6'd7);
    push("pause_r7_p0", 0, 32'h0);
    push("pause_r7_p1", 1, 32'h0);
    drain();
    write(6'd7, 32'h1234);
    push("r7_p0", 0, 32'h1234);
    push("r7_p1", 1, 32'h1234);
    drain();

    // Same-cycle write/read
    set_rs(ZERO, 6'd9);
    rd_index = 6'd9;
    wdata    = 32'hA5A5A5A5;
    #1;
`ifdef C5_REG_BANK_MP_BYPASS_EN
    push("same_cycle_r9", 1, 32'hA5A5A5A5);
`else
    push("same_cycle_r9", 1, 32'h0);
`endif
    drain();
    step();
    rd_index = ZERO;
    #1;
    push("next_cycle_r9", 1, 32'hA5A5A5A5);
    drain();
    set_rs(VEC, VEC);
    rd_index = VEC;
    wdata    = 32'h77;
    #1;
    push("same_cycle_vec_p0", 0, 32'h3C);
`ifdef C5_REG_BANK_MP_BYPASS_EN
    push("same_cycle_vec_p1", 1, 32'h77);
`else
    push("same_cycle_vec_p1", 1, 32'h0);
`endif
    drain();
    step();
    rd_index = ZERO;
    #1;
    push("next_cycle_vec_p1", 1, 32'h77);
    drain();

    // Reset during clear restarts the sweep; writes during clear are dropped
    write(6'd3, 32'h55);
    write(6'd20, 32'h66);
    set_rs(6'd3, 6'd20);
    push("pre_r3", 0, 32'h55);
    push("pre_r20", 1, 32'h66);
    drain();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd_index = 6'd3;
    wdata    = 32'hBAD;
    repeat (10) step();
    check("midclear_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    check("rst2_ie", 32'(intr_enable), 32'd0);
    rst_n = 1'b1;
    #1;
    count_busy("clear2");
    set_rs(6'd3, 6'd20);
    push("dropped_r3", 0, 32'h0);
    push("cleared_r20", 1, 32'h0);
    drain();
    set_rs(6'd5, 6'd9);
    push("cleared_r5", 0, 32'h0);
    push("cleared_r9", 1, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
